// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the iterative AES round scheduler.
//   sched_state_e : scheduler FSM states
//   MODE_*        : dp_mode encodings presented to the external round unit
//   nr_from_nk    : round count for a given key length in 32-bit words
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  localparam logic [1:0] MODE_ARK   = 2'd0;
  localparam logic [1:0] MODE_FULL  = 2'd1;
  localparam logic [1:0] MODE_FINAL = 2'd2;

  function automatic int unsigned nr_from_nk(input int unsigned nk);
    return nk + 32'd6;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-requester request
//   enable     : grants are only issued while high
//   accept     : strobe that commits the current winner as last_grant
//   grant      : one-hot grant (zero when disabled or no request)
//   grant_id   : index of the current winner
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Starts at 1 so requester 0 wins the first tie.
  logic last_grant_q;

  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
    grant = 2'b00;
    if (enable && (req != 2'b00)) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant_id;
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative round scheduler for a shared AES-128/192/256 round datapath.
// Picks one of two requesters round-robin, walks the external round unit through
// AddRoundKey, NR-1 full rounds and the final round, then hands the ciphertext
// out with the requester ID over valid/ready.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous abort of the block in flight
//   key_valid           : key schedule ready; gates new grants only
//   req_valid/ready/data: two block requesters, {req1, req0} packing
//   rk_idx, rk          : round-key index to the key store and its return
//   dp_in, dp_mode      : state and operation presented to the round unit
//   dp_out              : round-unit result, captured every RUN cycle
//   out_valid/ready/id/data : ciphertext output handshake
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = nr_from_nk(NK)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         key_valid,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] dp_in,
  output logic [1:0]   dp_mode,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_id,
  output logic [127:0] out_data
);

  localparam logic [3:0] LastRnd = 4'(NR);

  sched_state_e fsm_q;
  logic [127:0] state_q;
  logic         id_q;
  logic [3:0]   rnd_q;

  logic [1:0]   grant;
  logic         grant_id;
  logic         arb_enable;
  logic         accept;

  // The round unit reads rk straight from the key store; this port is only a tap.
  logic unused_rk;
  assign unused_rk = ^rk;

  // Flush outranks an accept, so it also suppresses the grant itself.
  assign arb_enable = (fsm_q == IDLE) && key_valid && !flush;
  assign accept     = |grant;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid),
    .enable   (arb_enable),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign rk_idx    = rnd_q;
  assign dp_in     = state_q;
  assign out_valid = (fsm_q == DONE);
  assign out_id    = id_q;
  assign out_data  = state_q;

  always_comb begin
    dp_mode = MODE_FULL;
    if (rnd_q == 4'd0) begin
      dp_mode = MODE_ARK;
    end else if (rnd_q == LastRnd) begin
      dp_mode = MODE_FINAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      id_q    <= 1'b0;
      rnd_q   <= 4'd0;
    end else if (flush) begin
      fsm_q <= IDLE;
      rnd_q <= 4'd0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= grant_id ? req_data[255:128] : req_data[127:0];
            id_q    <= grant_id;
            rnd_q   <= 4'd0;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= dp_out;
          // Wrap to 0 on the final round so rk_idx never runs past NR.
          if (rnd_q == LastRnd) begin
            rnd_q <= 4'd0;
            fsm_q <= DONE;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: an AES-128 instance (dut_a) and an
// AES-256 instance (dut_b), each wrapped by a behavioural round unit and key store.
module tb_aes_round_sched;
  import aes_sched_pkg::*;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         flush_a, key_valid_a, out_valid_a, out_ready_a, out_id_a;
  logic [1:0]   req_valid_a, req_ready_a, dp_mode_a;
  logic [255:0] req_data_a;
  logic [3:0]   rk_idx_a;
  logic [127:0] rk_a, dp_in_a, dp_out_a, out_data_a;

  logic         flush_b, key_valid_b, out_valid_b, out_ready_b, out_id_b;
  logic [1:0]   req_valid_b, req_ready_b, dp_mode_b;
  logic [255:0] req_data_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] rk_b, dp_in_b, dp_out_b, out_data_b;

  logic [31:0]  w     [0:59];
  logic [127:0] rks_a [0:15];
  logic [127:0] rks_b [0:15];
  logic [127:0] ct_b;

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] sb(input logic [7:0] x);
    int unsigned i;
    i = 32'(x);
    return SBOX[2047-8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
  endfunction

  // SubBytes + ShiftRows; byte r+4c sits at bits [127-8*(r+4c) -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = sb(s[127-8*(r+4*((c+r)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic [1:0] mode);
    logic [127:0] t;
    case (mode)
      MODE_ARK:  t = s;
      MODE_FULL: t = mix_cols(sub_shift(s));
      default:   t = sub_shift(s);
    endcase
    return t ^ k;
  endfunction

  function automatic logic [127:0] aes_ref_a(input logic [127:0] pt);
    logic [127:0] s;
    s = aes_round(pt, rks_a[0], MODE_ARK);
    for (int r = 1; r < 10; r++) s = aes_round(s, rks_a[r], MODE_FULL);
    return aes_round(s, rks_a[10], MODE_FINAL);
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  assign rk_a     = rks_a[rk_idx_a];
  assign rk_b     = rks_b[rk_idx_b];
  assign dp_out_a = aes_round(dp_in_a, rk_a, dp_mode_a);
  assign dp_out_b = aes_round(dp_in_b, rk_b, dp_mode_b);

  aes_round_sched #(.NK(4), .NR(10)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .key_valid(key_valid_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_data(req_data_a),
    .rk_idx(rk_idx_a), .rk(rk_a), .dp_in(dp_in_a), .dp_mode(dp_mode_a), .dp_out(dp_out_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_id(out_id_a), .out_data(out_data_a)
  );

  aes_round_sched #(.NK(8), .NR(14)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .key_valid(key_valid_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_data(req_data_b),
    .rk_idx(rk_idx_b), .rk(rk_b), .dp_in(dp_in_b), .dp_mode(dp_mode_b), .dp_out(dp_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_id(out_id_b), .out_data(out_data_b)
  );

  task automatic hw_reset();
    reset = 1'b1;
    flush_a = 1'b0; key_valid_a = 1'b0; req_valid_a = 2'b00; out_ready_a = 1'b1;
    flush_b = 1'b0; key_valid_b = 1'b0; req_valid_b = 2'b00; out_ready_b = 1'b1;
    req_data_a = '0; req_data_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise req_valid_a and wait (bounded) for a grant. Returns at negedge+1 just after
  // the accept edge; n is the number of extra cycles spent waiting.
  task automatic issue_a(input logic [1:0] valid, output logic [1:0] grant, output int n);
    n = 0;
    @(negedge clk);
    req_valid_a = valid;
    #1;
    while (req_ready_a == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    grant = req_ready_a;
    @(negedge clk); #1;
  endtask

  // Count cycles from the accept edge until out_valid_a is seen (bounded).
  task automatic wait_out_a(output int lat);
    lat = 0;
    while (out_valid_a !== 1'b1 && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    hw_reset();
    @(negedge clk); #1;
    checks++; if (req_ready_a !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
    checks++; if (out_id_a !== 1'b0) begin failures++; $display("FAIL reset_out_id got=%b exp=0", out_id_a); end
    checks++; if (out_data_a !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data_a); end
    checks++; if (rk_idx_a !== 4'd0) begin failures++; $display("FAIL reset_rk_idx got=%0d exp=0", rk_idx_a); end
    checks++; if (dp_mode_a !== MODE_ARK) begin failures++; $display("FAIL reset_dp_mode got=%0d exp=0", dp_mode_a); end
    checks++; if (dp_in_a !== 128'h0) begin failures++; $display("FAIL reset_dp_in got=%h exp=0", dp_in_a); end
    checks++; if (out_valid_b !== 1'b0) begin failures++; $display("FAIL reset_b_out_valid got=%b exp=0", out_valid_b); end
  endtask

  task automatic test_fips128();
    logic [1:0] g;
    int n;
    logic [1:0] exp_mode;
    hw_reset();
    key_valid_a = 1'b1; out_ready_a = 1'b0; req_data_a = {128'h0, PT};
    issue_a(2'b01, g, n);
    req_valid_a = 2'b00;
    checks++; if (g !== 2'b01) begin failures++; $display("FAIL f128_grant got=%b exp=01", g); end
    for (int i = 0; i <= 10; i++) begin
      exp_mode = (i == 0) ? MODE_ARK : ((i == 10) ? MODE_FINAL : MODE_FULL);
      checks++; if (rk_idx_a !== 4'(i)) begin failures++; $display("FAIL f128_rk_idx got=%0d exp=%0d", rk_idx_a, i); end
      checks++; if (dp_mode_a !== exp_mode) begin failures++; $display("FAIL f128_dp_mode rnd=%0d got=%0d exp=%0d", i, dp_mode_a, exp_mode); end
      checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL f128_early_valid rnd=%0d got=%b exp=0", i, out_valid_a); end
      @(negedge clk); #1;
    end
    checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL f128_latency out_valid got=%b exp=1 at 11", out_valid_a); end
    checks++; if (out_data_a !== CT128) begin failures++; $display("FAIL f128_data got=%h exp=%h", out_data_a, CT128); end
    checks++; if (out_id_a !== 1'b0) begin failures++; $display("FAIL f128_id got=%b exp=0", out_id_a); end
    checks++; if (rk_idx_a !== 4'd0) begin failures++; $display("FAIL f128_done_rk_idx got=%0d exp=0", rk_idx_a); end
    out_ready_a = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL f128_release got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_fips256();
    int n;
    int lat;
    hw_reset();
    key_valid_b = 1'b1; req_data_b = {128'h0, PT};
    @(negedge clk);
    req_valid_b = 2'b01;
    #1;
    n = 0;
    while (req_ready_b == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (req_ready_b !== 2'b01) begin failures++; $display("FAIL f256_grant got=%b exp=01", req_ready_b); end
    @(negedge clk); #1;
    req_valid_b = 2'b00;
    lat = 0;
    while (out_valid_b !== 1'b1 && lat < 40) begin @(negedge clk); #1; lat++; end
    checks++; if (lat != 15) begin failures++; $display("FAIL f256_latency got=%0d exp=15", lat); end
    checks++; if (out_data_b !== CT256) begin failures++; $display("FAIL f256_data got=%h exp=%h", out_data_b, CT256); end
    checks++; if (out_id_b !== 1'b0) begin failures++; $display("FAIL f256_id got=%b exp=0", out_id_b); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    logic [1:0] exp_g;
    int n;
    int lat;
    hw_reset();
    key_valid_a = 1'b1; out_ready_a = 1'b1; req_data_a = {PT_B, PT};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      issue_a(2'b11, g, n);
      checks++; if (g !== exp_g) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, g, exp_g); end
      if (k > 0) begin
        checks++; if (n != 0) begin failures++; $display("FAIL rr_gap k=%0d got=%0d exp=0", k, n); end
      end
      wait_out_a(lat);
      checks++; if (lat != 11) begin failures++; $display("FAIL rr_latency k=%0d got=%0d exp=11", k, lat); end
      checks++; if (out_id_a !== 1'(k % 2)) begin failures++; $display("FAIL rr_id k=%0d got=%b exp=%0d", k, out_id_a, k % 2); end
      checks++; if (out_data_a !== ((k % 2 == 1) ? ct_b : CT128)) begin failures++; $display("FAIL rr_data k=%0d got=%h", k, out_data_a); end
    end
    req_valid_a = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    int n;
    int lat;
    hw_reset();
    key_valid_a = 1'b1; out_ready_a = 1'b0; req_data_a = {PT_B, PT};
    issue_a(2'b01, g, n);
    req_valid_a = 2'b10;
    wait_out_a(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (out_valid_a !== 1'b1) begin failures++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, out_valid_a); end
      checks++; if (out_data_a !== CT128) begin failures++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, out_data_a, CT128); end
      checks++; if (out_id_a !== 1'b0) begin failures++; $display("FAIL bp_id i=%0d got=%b exp=0", i, out_id_a); end
      checks++; if (req_ready_a !== 2'b00) begin failures++; $display("FAIL bp_req_ready i=%0d got=%b exp=00", i, req_ready_a); end
    end
    out_ready_a = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid_a); end
    checks++; if (req_ready_a !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", req_ready_a); end
    @(negedge clk); #1;
    req_valid_a = 2'b00;
    wait_out_a(lat);
    checks++; if (out_data_a !== ct_b) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", out_data_a, ct_b); end
    checks++; if (out_id_a !== 1'b1) begin failures++; $display("FAIL bp_next_id got=%b exp=1", out_id_a); end
  endtask

  task automatic test_flush();
    logic [1:0] g;
    int n;
    int lat;
    hw_reset();
    key_valid_a = 1'b1; out_ready_a = 1'b1; req_data_a = {PT_B, PT};
    issue_a(2'b01, g, n);
    req_valid_a = 2'b10;
    n = 0;
    while (rk_idx_a != 4'd5 && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (rk_idx_a !== 4'd5) begin failures++; $display("FAIL flush_reach_rnd5 got=%0d exp=5", rk_idx_a); end
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid_a); end
    checks++; if (rk_idx_a !== 4'd0) begin failures++; $display("FAIL flush_rk_idx got=%0d exp=0", rk_idx_a); end
    checks++; if (req_ready_a !== 2'b10) begin failures++; $display("FAIL flush_idle_grant got=%b exp=10", req_ready_a); end
    @(negedge clk); #1;
    req_valid_a = 2'b00;
    wait_out_a(lat);
    checks++; if (lat != 11) begin failures++; $display("FAIL flush_next_latency got=%0d exp=11", lat); end
    checks++; if (out_data_a !== ct_b) begin failures++; $display("FAIL flush_next_data got=%h exp=%h", out_data_a, ct_b); end
    checks++; if (out_id_a !== 1'b1) begin failures++; $display("FAIL flush_next_id got=%b exp=1", out_id_a); end
    // Flush in IDLE must block a grant that would otherwise happen.
    @(negedge clk);
    req_valid_a = 2'b01; flush_a = 1'b1;
    #1;
    checks++; if (req_ready_a !== 2'b00) begin failures++; $display("FAIL flush_blocks_grant got=%b exp=00", req_ready_a); end
    @(negedge clk);
    flush_a = 1'b0; req_valid_a = 2'b00;
  endtask

  task automatic test_reset_midrun();
    logic [1:0] g;
    int n;
    int lat;
    hw_reset();
    key_valid_a = 1'b1; out_ready_a = 1'b1; req_data_a = {PT_B, PT};
    issue_a(2'b10, g, n);
    req_valid_a = 2'b00;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1; key_valid_a = 1'b0;
    #1;
    checks++; if (out_valid_a !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid_a); end
    checks++; if (out_id_a !== 1'b0) begin failures++; $display("FAIL rst_mid_id got=%b exp=0", out_id_a); end
    checks++; if (out_data_a !== 128'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", out_data_a); end
    checks++; if (rk_idx_a !== 4'd0) begin failures++; $display("FAIL rst_mid_rk_idx got=%0d exp=0", rk_idx_a); end
    checks++; if (dp_in_a !== 128'h0) begin failures++; $display("FAIL rst_mid_dp_in got=%h exp=0", dp_in_a); end
    checks++; if (dp_mode_a !== MODE_ARK) begin failures++; $display("FAIL rst_mid_dp_mode got=%0d exp=0", dp_mode_a); end
    @(negedge clk);
    reset = 1'b0; req_valid_a = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (req_ready_a !== 2'b00) begin failures++; $display("FAIL rst_nokey_grant i=%0d got=%b exp=00", i, req_ready_a); end
    end
    key_valid_a = 1'b1;
    #1;
    checks++; if (req_ready_a !== 2'b01) begin failures++; $display("FAIL rst_first_tie got=%b exp=01", req_ready_a); end
    @(negedge clk); #1;
    req_valid_a = 2'b00;
    wait_out_a(lat);
    checks++; if (lat != 11) begin failures++; $display("FAIL rst_next_latency got=%0d exp=11", lat); end
    checks++; if (out_data_a !== CT128) begin failures++; $display("FAIL rst_next_data got=%h exp=%h", out_data_a, CT128); end
  endtask

  initial begin
    reset = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rks_a[r] = '0;
      rks_b[r] = '0;
    end
    expand({KEY128, 128'h0}, 4);
    for (int r = 0; r < 11; r++) rks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(KEY256, 8);
    for (int r = 0; r < 15; r++) rks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    ct_b = aes_ref_a(PT_B);

    test_reset();
    test_fips128();
    test_fips256();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_midrun();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative round scheduler for the shared AES-128/192/256 encryption round datapath. It arbitrates round-robin between two block requesters, then steps one combinational round unit through AddRoundKey, Nr-1 full rounds and the final round. It supplies the round-key index to the external key-expansion store and returns each ciphertext with the requester ID over a valid/ready handshake. It sits between the input sources (switch/UART front ends) and the round logic.

## Interface
- NK, 4: key length in 32-bit words (4/6/8).
- NR, 10: round count (10/12/14); must equal NK+6.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous abort of the block in flight.
- key_valid  in  1  expanded key schedule ready; no grant while low.
- req_valid  in  2  per-requester block valid.
- req_ready  out  2  per-requester accept (one-hot or zero).
- req_data  in  256  {req1 block, req0 block}, 128 bits each.
- rk_idx  out  4  round-key index 0..NR to the key store.
- rk  in  128  round key for rk_idx (combinational return).
- dp_in  out  128  state fed to the round unit.
- dp_mode  out  2  0=ARK only, 1=full round, 2=final round (no MixColumns), 3=unused.
- dp_out  in  128  combinational round-unit result.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts.
- out_id  out  1  requester that issued the block.
- out_data  out  128  ciphertext.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if key_valid and any req_valid, raise req_ready for the winner. The handshake completes in the same cycle.
  - Winner is the sole valid requester.
  - With both valid, winner is the requester not served last.
  - last_grant resets to 1, so req0 wins the first tie.
- Accept edge: state_reg<=selected block, id_reg<=winner, rnd<=0, last_grant<=winner, go to RUN.
- RUN: dp_in=state_reg, rk_idx=rnd.
  - dp_mode=0 when rnd=0, 1 when 1<=rnd<=NR-1, 2 when rnd=NR.
  - Each edge: state_reg<=dp_out, rnd<=rnd+1.
  - After the rnd=NR edge, go to DONE.
- DONE: out_valid=1; out_data=state_reg and out_id=id_reg, both held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE.
- req_ready is 0 outside IDLE. No accept in the cycle DONE completes.
- flush: from any state, go to IDLE next edge and drop the block. No output is produced. last_grant keeps its updated value. flush outranks out_ready and accept in the same cycle.
- key_valid dropping during RUN/DONE does not affect the block in flight.
- rk_idx is a 4-bit counter and never exceeds NR. dp_mode=3 is never driven.

## Timing
- Reset values: req_ready=0, out_valid=0, out_id=0, out_data=0, rk_idx=0, dp_mode=0, dp_in=0. FSM=IDLE, rnd=0, last_grant=1.
- Latency: out_valid rises NR+1 cycles after the accept edge (11 for AES-128).
- Throughput: one block per NR+3 cycles with out_ready held high.
- rk and dp_out are sampled in the same cycle as rk_idx/dp_in are presented. Key-store and round-unit paths must close in one cycle.
- Reset mid-RUN clears immediately, asynchronously; the next block starts from a clean accept.

## Structure
- Package aes_sched_pkg:
  - state enum {IDLE, RUN, DONE};
  - dp_mode constants MODE_ARK=0, MODE_FULL=1, MODE_FINAL=2;
  - NR-from-NK helper function.
- Sub-module rr_arb2: 2-input round-robin arbiter with a last_grant register and an update-on-accept strobe.
- Round unit and key expansion stay outside. The scheduler holds only the state register, counter, FSM and arbiter.

## Test plan
- FIPS-197 AES-128: key 000102…0f, req0 block 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0, out_valid 11 cycles after accept.
- AES-256 (NK=8, NR=14): key 000102…1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089, latency 15 cycles.
- Both requesters valid continuously -> grants alternate 0,1,0,1. Each out_id matches its grant. No requester waits more than one block.
- out_ready low for 5 cycles in DONE -> out_data/out_id stable, req_ready stays 0, release completes one transfer.
- flush at rnd=5 -> no out_valid, FSM IDLE next cycle. A pending request is then accepted and produces the correct ciphertext.
- reset asserted mid-RUN and with key_valid=0 -> all outputs at reset values. No grant until key_valid=1.
